usr_serdes_ctrl: RTL and testbench
==================================

Name: usr_serdes_ctrl

Overview:
- Sequencing controller for one universal shift register (USR) of width WIDTH; owns its mode, par_in, ser_in_right and ser_in_left inputs and reads back q.
- Accepts one operation at a time over a valid/ready handshake: transmit (parallel load, then serialize) or receive (clear, then deserialize). Bit order is selectable per operation.
- Sits between the link-side serial pins and the word-side logic.
- USR mode encoding is fixed:
  - 00: hold
  - 01: shift right; ser_in_left enters the MSB
  - 10: shift left; ser_in_right enters the LSB
  - 11: parallel load

Parameters:
- WIDTH, 8, USR and data word width; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  operation request.
- op_ready  output  1  high only in IDLE.
- op_rx  input  1  0 = transmit, 1 = receive; sampled at accept.
- op_lsb_first  input  1  0 = MSB first, 1 = LSB first; sampled at accept.
- op_data  input  WIDTH  transmit word; sampled at accept.
- abort  input  1  synchronous abort; returns the controller to IDLE.
- ser_rx  input  1  serial receive bit, sampled in SHIFT.
- ser_tx  output  1  serial transmit bit.
- ser_tx_en  output  1  high while ser_tx carries a valid bit.
- rx_data  output  WIDTH  received word; registered.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high in any state other than IDLE.
- usr_mode  output  2  USR mode.
- usr_par_in  output  WIDTH  USR parallel input.
- usr_ser_in_right  output  1  USR serial input at the LSB end.
- usr_ser_in_left  output  1  USR serial input at the MSB end.
- usr_q  input  WIDTH  USR contents.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. The state register, counter, op_rx/op_lsb_first/data latches, rx_data and done are flops. All usr_* outputs, ser_tx, ser_tx_en, op_ready and busy are combinational from the state and the latched values.
- Reset (async): state IDLE, counter 0, done 0, rx_data 0. As a result op_ready=1, busy=0, usr_mode=00, usr_par_in=0, usr_ser_in_*=0, ser_tx=0, ser_tx_en=0.
- IDLE:
  - usr_mode=00.
  - Accept occurs on op_valid & op_ready at a rising edge; the controller latches op_rx, op_lsb_first and op_data, then goes to LOAD.
- LOAD (1 cycle):
  - usr_mode=11.
  - usr_par_in = latched data for transmit, 0 for receive.
  - Counter is set to WIDTH; next state is SHIFT.
- SHIFT (exactly WIDTH cycles):
  - Counter decrements each cycle; the last SHIFT cycle is the one with counter==1.
  - Transmit, MSB first: usr_mode=10, usr_ser_in_right=0, ser_tx=usr_q[WIDTH-1].
  - Transmit, LSB first: usr_mode=01, usr_ser_in_left=0, ser_tx=usr_q[0].
  - Transmit: ser_tx_en=1 in every SHIFT cycle.
  - Receive, MSB first: usr_mode=10, usr_ser_in_right=ser_rx.
  - Receive, LSB first: usr_mode=01, usr_ser_in_left=ser_rx.
  - Receive: ser_tx=0 and ser_tx_en=0.
  - The unused serial input is always 0.
- DONE (1 cycle):
  - usr_mode=00.
  - done=1 in this cycle.
  - Receive only: rx_data captures usr_q at the edge entering DONE.
  - Next state is IDLE.
- Latency: accept at edge k → LOAD in cycle k+1 → SHIFT in cycles k+2..k+1+WIDTH → DONE in cycle k+2+WIDTH → op_ready=1 in cycle k+3+WIDTH. Back-to-back operations have a period of WIDTH+3 cycles.
- Ordering: the first transmitted bit is op_data[WIDTH-1] (MSB first) or op_data[0] (LSB first). The first received bit lands in rx_data[WIDTH-1] (MSB first) or rx_data[0] (LSB first).
- abort:
  - Valid in LOAD, SHIFT or DONE. The next state is IDLE and the counter is cleared.
  - done is not pulsed and rx_data is not updated.
  - abort has priority over every other transition. In IDLE it has no effect, and an op_valid in the same cycle is still accepted.
- op_data and op_rx changing while busy have no effect. op_valid held while busy is not accepted until IDLE.
- rst_n asserted mid-operation forces reset values immediately (asynchronously). rx_data is cleared.

Test Plan:
- Reset: rst_n=0 for 2 cycles with op_valid=1 → op_ready=1, busy=0, usr_mode=00, done=0, rx_data=0x00. Release reset → accept on the first edge.
- Transmit MSB first, op_data=0xCC: accept → LOAD with usr_mode=11 and usr_par_in=0xCC → 8 SHIFT cycles with usr_mode=10, ser_tx_en=1, ser_tx=1,1,0,0,1,1,0,0 → done pulse in cycle 10 after accept → op_ready=1 in cycle 11.
- Transmit LSB first, op_data=0xA5: usr_mode=01 in SHIFT, ser_tx=1,0,1,0,0,1,0,1.
- Receive MSB first, ser_rx=1,0,1,0,1,0,1,0 → LOAD par_in=0x00 → rx_data=0xAA with done=1. Same bits LSB first → rx_data=0x55.
- abort asserted in the 4th SHIFT cycle of a receive → IDLE next cycle, no done pulse, rx_data keeps its previous value (0x55). A following transmit of 0x0F completes normally.
- Back-to-back: op_valid held high for 2 operations → second accept exactly 11 cycles after the first (WIDTH=8). Mid-shift reset → all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/usr_serdes_ctrl.sv
// usr_serdes_ctrl: sequences one universal shift register through load-then-shift
// to serialize a word onto ser_tx or deserialize ser_rx into rx_data.
module usr_serdes_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             op_rx,
    input  logic             op_lsb_first,
    input  logic [WIDTH-1:0] op_data,
    input  logic             abort,
    input  logic             ser_rx,
    output logic             ser_tx,
    output logic             ser_tx_en,
    output logic [WIDTH-1:0] rx_data,
    output logic             done,
    output logic             busy,
    output logic [1:0]       usr_mode,
    output logic [WIDTH-1:0] usr_par_in,
    output logic             usr_ser_in_right,
    output logic             usr_ser_in_left,
    input  logic [WIDTH-1:0] usr_q
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rx_l;
    logic             lsb_l;
    logic [WIDTH-1:0] data_l;
    logic             shifting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rx_l    <= 1'b0;
            lsb_l   <= 1'b0;
            data_l  <= '0;
            rx_data <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (op_valid) begin
                        rx_l   <= op_rx;
                        lsb_l  <= op_lsb_first;
                        data_l <= op_data;
                        state  <= LOAD;
                    end
                    LOAD: begin
                        cnt   <= CNT_W'(WIDTH);
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            // capture the word as it will look after this final shift
                            if (rx_l)
                                rx_data <= lsb_l ? {ser_rx, usr_q[WIDTH-1:1]}
                                                 : {usr_q[WIDTH-2:0], ser_rx};
                        end
                    end
                    DONE: state <= IDLE;
                endcase
            end
        end
    end

    assign shifting         = state == SHIFT;
    assign op_ready         = state == IDLE;
    assign busy             = state != IDLE;
    assign usr_mode         = state == LOAD ? 2'b11 : shifting ? (lsb_l ? 2'b01 : 2'b10) : 2'b00;
    assign usr_par_in       = (state == LOAD && !rx_l) ? data_l : '0;
    assign usr_ser_in_right = shifting && rx_l && !lsb_l && ser_rx;
    assign usr_ser_in_left  = shifting && rx_l && lsb_l && ser_rx;
    assign ser_tx_en        = shifting && !rx_l;
    assign ser_tx           = ser_tx_en && (lsb_l ? usr_q[0] : usr_q[WIDTH-1]);
endmodule

// File: tb/tb_usr_serdes_ctrl.sv
// tb_usr_serdes_ctrl: directed bench for usr_serdes_ctrl with a behavioural USR
// attached, checking transmit/receive ordering, abort, back-to-back and reset.
module tb_usr_serdes_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic       op_rx = 1'b0;
    logic       op_lsb_first = 1'b0;
    logic [7:0] op_data = 8'h00;
    logic       abort = 1'b0;
    logic       ser_rx = 1'b0;
    logic       ser_tx;
    logic       ser_tx_en;
    logic [7:0] rx_data;
    logic       done;
    logic       busy;
    logic [1:0] usr_mode;
    logic [7:0] usr_par_in;
    logic       usr_ser_in_right;
    logic       usr_ser_in_left;
    logic [7:0] usr_q = 8'h00;
    int         checks = 0;
    int         failures = 0;

    usr_serdes_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_rx(op_rx), .op_lsb_first(op_lsb_first), .op_data(op_data),
        .abort(abort), .ser_rx(ser_rx), .ser_tx(ser_tx), .ser_tx_en(ser_tx_en),
        .rx_data(rx_data), .done(done), .busy(busy), .usr_mode(usr_mode),
        .usr_par_in(usr_par_in), .usr_ser_in_right(usr_ser_in_right),
        .usr_ser_in_left(usr_ser_in_left), .usr_q(usr_q)
    );

    always #5 clk = ~clk;

    // the shift register being controlled
    always @(posedge clk) begin
        case (usr_mode)
            2'b01: usr_q <= {usr_ser_in_left, usr_q[7:1]};
            2'b10: usr_q <= {usr_q[6:0], usr_ser_in_right};
            2'b11: usr_q <= usr_par_in;
            default: usr_q <= usr_q;
        endcase
    end

    // called just after a negedge in IDLE; returns at the negedge of the LOAD cycle
    task automatic start_op(input logic rx, input logic lsb, input logic [7:0] data);
        op_valid = 1'b1; op_rx = rx; op_lsb_first = lsb; op_data = data;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic test_reset;
        op_valid = 1'b1; op_rx = 1'b0; op_lsb_first = 1'b0; op_data = 8'h3C;
        repeat (2) @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b exp 1", op_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (usr_mode !== 2'b00) begin failures++; $display("FAIL rst_mode got %b exp 00", usr_mode); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_rx_data got %h exp 00", rx_data); end
        checks++; if ({ser_tx, ser_tx_en, usr_ser_in_right, usr_ser_in_left} !== 4'b0000) begin failures++; $display("FAIL rst_serial got %b exp 0000", {ser_tx, ser_tx_en, usr_ser_in_right, usr_ser_in_left}); end
        checks++; if (usr_par_in !== 8'h00) begin failures++; $display("FAIL rst_par_in got %h exp 00", usr_par_in); end
        rst_n = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        checks++; if (usr_mode !== 2'b11 || usr_par_in !== 8'h3C) begin failures++; $display("FAIL rst_first_accept got mode=%b par=%h exp 11/3c", usr_mode, usr_par_in); end
        repeat (10) @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL rst_first_op_end got %b exp 1", op_ready); end
    endtask

    task automatic test_tx_msb;
        logic [7:0] seq = 8'h33; // bit i is the i-th transmitted bit of 0xCC
        start_op(1'b0, 1'b0, 8'hCC);
        checks++; if (usr_mode !== 2'b11) begin failures++; $display("FAIL txm_load_mode got %b exp 11", usr_mode); end
        checks++; if (usr_par_in !== 8'hCC) begin failures++; $display("FAIL txm_load_par got %h exp cc", usr_par_in); end
        checks++; if (busy !== 1'b1 || op_ready !== 1'b0) begin failures++; $display("FAIL txm_busy got busy=%b ready=%b exp 1/0", busy, op_ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (usr_mode !== 2'b10 || ser_tx_en !== 1'b1 || usr_ser_in_right !== 1'b0) begin failures++; $display("FAIL txm_shift%0d got mode=%b en=%b sir=%b exp 10/1/0", i, usr_mode, ser_tx_en, usr_ser_in_right); end
            checks++; if (ser_tx !== seq[i]) begin failures++; $display("FAIL txm_bit%0d got %b exp %b", i, ser_tx, seq[i]); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1 || usr_mode !== 2'b00 || ser_tx_en !== 1'b0) begin failures++; $display("FAIL txm_done got done=%b mode=%b en=%b exp 1/00/0", done, usr_mode, ser_tx_en); end
        @(negedge clk);
        checks++; if (op_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL txm_idle got ready=%b done=%b exp 1/0", op_ready, done); end
    endtask

    task automatic test_tx_lsb;
        logic [7:0] seq = 8'hA5; // LSB first: i-th bit is data[i]
        start_op(1'b0, 1'b1, 8'hA5);
        checks++; if (usr_par_in !== 8'hA5) begin failures++; $display("FAIL txl_load_par got %h exp a5", usr_par_in); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (usr_mode !== 2'b01 || usr_ser_in_left !== 1'b0) begin failures++; $display("FAIL txl_shift%0d got mode=%b sil=%b exp 01/0", i, usr_mode, usr_ser_in_left); end
            checks++; if (ser_tx !== seq[i]) begin failures++; $display("FAIL txl_bit%0d got %b exp %b", i, ser_tx, seq[i]); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL txl_done got %b exp 1", done); end
        @(negedge clk);
    endtask

    task automatic test_rx(input logic lsb, input logic [7:0] expv);
        logic [7:0] bits = 8'h55; // 1,0,1,0,1,0,1,0 in send order
        start_op(1'b1, lsb, 8'hFF);
        checks++; if (usr_mode !== 2'b11 || usr_par_in !== 8'h00) begin failures++; $display("FAIL rx%0d_load got mode=%b par=%h exp 11/00", lsb, usr_mode, usr_par_in); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ser_rx = bits[i];
            #1;
            checks++; if (usr_mode !== (lsb ? 2'b01 : 2'b10) || ser_tx_en !== 1'b0 || ser_tx !== 1'b0) begin failures++; $display("FAIL rx%0d_shift%0d got mode=%b en=%b tx=%b", lsb, i, usr_mode, ser_tx_en, ser_tx); end
            checks++; if ((lsb ? usr_ser_in_left : usr_ser_in_right) !== bits[i] || (lsb ? usr_ser_in_right : usr_ser_in_left) !== 1'b0) begin failures++; $display("FAIL rx%0d_serin%0d got l=%b r=%b bit=%b", lsb, i, usr_ser_in_left, usr_ser_in_right, bits[i]); end
        end
        @(negedge clk);
        ser_rx = 1'b0;
        checks++; if (done !== 1'b1 || rx_data !== expv) begin failures++; $display("FAIL rx%0d_result got done=%b data=%h exp 1/%h", lsb, done, rx_data, expv); end
        @(negedge clk);
        checks++; if (op_ready !== 1'b1 || rx_data !== expv) begin failures++; $display("FAIL rx%0d_hold got ready=%b data=%h exp 1/%h", lsb, op_ready, rx_data, expv); end
    endtask

    task automatic test_abort;
        logic [7:0] seq = 8'hF0; // 0x0F sent MSB first: 0,0,0,0,1,1,1,1
        logic       seen_done = 1'b0;
        start_op(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ser_rx = 1'b1;
            if (i == 3) abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0; ser_rx = 1'b0;
        checks++; if (op_ready !== 1'b1 || usr_mode !== 2'b00) begin failures++; $display("FAIL abort_idle got ready=%b mode=%b exp 1/00", op_ready, usr_mode); end
        checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL abort_rx_data got %h exp 55", rx_data); end
        for (int i = 0; i < 8; i++) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got %b exp 0", seen_done); end
        start_op(1'b0, 1'b0, 8'h0F);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (ser_tx !== seq[i] || ser_tx_en !== 1'b1) begin failures++; $display("FAIL abort_tx_bit%0d got %b/%b exp %b/1", i, ser_tx, ser_tx_en, seq[i]); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1 || rx_data !== 8'h55) begin failures++; $display("FAIL abort_tx_done got done=%b data=%h exp 1/55", done, rx_data); end
        @(negedge clk);
    endtask

    task automatic test_abort_idle;
        abort = 1'b1;
        start_op(1'b0, 1'b0, 8'h42);
        abort = 1'b0;
        checks++; if (usr_mode !== 2'b11 || usr_par_in !== 8'h42) begin failures++; $display("FAIL abort_idle_accept got mode=%b par=%h exp 11/42", usr_mode, usr_par_in); end
        repeat (10) @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL abort_idle_end got %b exp 1", op_ready); end
    endtask

    task automatic test_back_to_back;
        op_valid = 1'b1; op_rx = 1'b0; op_lsb_first = 1'b0; op_data = 8'h81;
        @(negedge clk);
        checks++; if (usr_mode !== 2'b11 || usr_par_in !== 8'h81) begin failures++; $display("FAIL b2b_first_load got mode=%b par=%h exp 11/81", usr_mode, usr_par_in); end
        op_data = 8'h7E;
        @(negedge clk);
        checks++; if (ser_tx !== 1'b1) begin failures++; $display("FAIL b2b_first_bit got %b exp 1", ser_tx); end
        repeat (9) @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL b2b_gap_idle got %b exp 1", op_ready); end
        @(negedge clk);
        op_valid = 1'b0;
        checks++; if (usr_mode !== 2'b11 || usr_par_in !== 8'h7E) begin failures++; $display("FAIL b2b_second_load got mode=%b par=%h exp 11/7e", usr_mode, usr_par_in); end
    endtask

    task automatic test_reset_mid;
        repeat (3) @(negedge clk);
        checks++; if (ser_tx_en !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre got en=%b busy=%b exp 1/1", ser_tx_en, busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (op_ready !== 1'b1 || busy !== 1'b0 || usr_mode !== 2'b00) begin failures++; $display("FAIL rstmid_state got ready=%b busy=%b mode=%b exp 1/0/00", op_ready, busy, usr_mode); end
        checks++; if (ser_tx !== 1'b0 || ser_tx_en !== 1'b0 || usr_par_in !== 8'h00) begin failures++; $display("FAIL rstmid_out got tx=%b en=%b par=%h exp 0/0/00", ser_tx, ser_tx_en, usr_par_in); end
        checks++; if (rx_data !== 8'h00 || done !== 1'b0) begin failures++; $display("FAIL rstmid_regs got data=%h done=%b exp 00/0", rx_data, done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL rstmid_release got %b exp 1", op_ready); end
    endtask

    initial begin
        test_reset;
        test_tx_msb;
        test_tx_lsb;
        test_rx(1'b0, 8'hAA);
        test_rx(1'b1, 8'h55);
        test_abort;
        test_abort_idle;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
